cordic_iter: RTL and testbench

- Parametrised iterative CORDIC engine. Embeds its own arctangent table (degrees, Q16.16) and runs one micro-rotation per clock.
- Supports rotation mode (rotate vector (x,y) by angle z) and vectoring mode (drive y to 0, accumulate angle in z).
- Adds quadrant pre-rotation so the full ±180° range converges.
- Start/busy/done handshake. Serves as the shared trig/magnitude resource for downstream signal-processing blocks.

---
 rtl/cordic_iter.sv | 238 +++++++++++++++++++++++
 tb/tb_cordic_iter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and vectoring
// modes, quadrant pre-rotation for full +/-180 degree coverage, start/busy/done handshake.
module cordic_iter #(
  parameter int DW   = 32,
  parameter int ITER = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  input  logic signed [31:0]   z_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] y_out,
  output logic signed [31:0]   z_out
);

  localparam int XW = DW + 2;
  localparam logic signed [31:0]   NINETY  = 32'sd5898240;
  localparam logic [4:0]           LAST    = 5'(ITER - 1);
  localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Arctangent of 2^-idx in degrees, Q16.16
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd2949120;
      5'd1:    atan_lut = 32'sd1740967;
      5'd2:    atan_lut = 32'sd919879;
      5'd3:    atan_lut = 32'sd466945;
      5'd4:    atan_lut = 32'sd234378;
      5'd5:    atan_lut = 32'sd117303;
      5'd6:    atan_lut = 32'sd58666;
      5'd7:    atan_lut = 32'sd29334;
      5'd8:    atan_lut = 32'sd14667;
      5'd9:    atan_lut = 32'sd7333;
      5'd10:   atan_lut = 32'sd3666;
      5'd11:   atan_lut = 32'sd1833;
      5'd12:   atan_lut = 32'sd916;
      5'd13:   atan_lut = 32'sd458;
      5'd14:   atan_lut = 32'sd229;
      5'd15:   atan_lut = 32'sd114;
      5'd16:   atan_lut = 32'sd57;
      5'd17:   atan_lut = 32'sd28;
      5'd18:   atan_lut = 32'sd14;
      5'd19:   atan_lut = 32'sd7;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  // Clamp the widened datapath value back into the DW-bit signed port range
  function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) begin
      sat = SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      sat = SAT_MIN[DW-1:0];
    end else begin
      sat = v[DW-1:0];
    end
  endfunction

  state_t                state_r;
  state_t                state_nx_s;
  logic                  mode_r;
  logic signed [XW-1:0]  x_r;
  logic signed [XW-1:0]  y_r;
  logic signed [31:0]    z_r;
  logic [4:0]            cnt_r;

  logic                  load_s;
  logic                  step_s;
  logic                  last_s;

  logic signed [XW-1:0]  x_ext_s;
  logic signed [XW-1:0]  y_ext_s;
  logic signed [XW-1:0]  x_pre_s;
  logic signed [XW-1:0]  y_pre_s;
  logic signed [31:0]    z_pre_s;

  logic                  d_pos_s;
  logic signed [XW-1:0]  x_sh_s;
  logic signed [XW-1:0]  y_sh_s;
  logic signed [XW-1:0]  x_nx_s;
  logic signed [XW-1:0]  y_nx_s;
  logic signed [31:0]    z_nx_s;

  assign x_ext_s = {{2{x_in[DW-1]}}, x_in};
  assign y_ext_s = {{2{y_in[DW-1]}}, y_in};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == LAST) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Control decode from the current state
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    last_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        load_s = start;
      end
      S_RUN: begin
        step_s = 1'b1;
        last_s = (cnt_r == LAST);
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Quadrant pre-rotation so the micro-rotations only need to cover +/-90 degrees
  always_comb begin
    x_pre_s = x_ext_s;
    y_pre_s = y_ext_s;
    z_pre_s = z_in;
    if (mode == 1'b0) begin
      if (z_in > NINETY) begin
        x_pre_s = -y_ext_s;
        y_pre_s = x_ext_s;
        z_pre_s = z_in - NINETY;
      end else if (z_in < -NINETY) begin
        x_pre_s = y_ext_s;
        y_pre_s = -x_ext_s;
        z_pre_s = z_in + NINETY;
      end else begin
        z_pre_s = z_in;
      end
    end else begin
      if (x_ext_s[XW-1] && !y_ext_s[XW-1]) begin
        x_pre_s = y_ext_s;
        y_pre_s = -x_ext_s;
        z_pre_s = z_in + NINETY;
      end else if (x_ext_s[XW-1] && y_ext_s[XW-1]) begin
        x_pre_s = -y_ext_s;
        y_pre_s = x_ext_s;
        z_pre_s = z_in - NINETY;
      end else begin
        z_pre_s = z_in;
      end
    end
  end

  // One micro-rotation on the working registers
  always_comb begin
    x_sh_s  = x_r >>> cnt_r;
    y_sh_s  = y_r >>> cnt_r;
    d_pos_s = mode_r ? y_r[XW-1] : ~z_r[31];
    if (d_pos_s) begin
      x_nx_s = x_r - y_sh_s;
      y_nx_s = y_r + x_sh_s;
      z_nx_s = z_r - atan_lut(cnt_r);
    end else begin
      x_nx_s = x_r + y_sh_s;
      y_nx_s = y_r - x_sh_s;
      z_nx_s = z_r + atan_lut(cnt_r);
    end
  end

  // Datapath, counter and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= 32'sd0;
      cnt_r  <= 5'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= 32'sd0;
    end else begin
      done <= 1'b0;
      if (load_s) begin
        mode_r <= mode;
        x_r    <= x_pre_s;
        y_r    <= y_pre_s;
        z_r    <= z_pre_s;
        cnt_r  <= 5'd0;
        busy   <= 1'b1;
      end else if (step_s) begin
        x_r   <= x_nx_s;
        y_r   <= y_nx_s;
        z_r   <= z_nx_s;
        cnt_r <= cnt_r + 5'd1;
        if (last_s) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          x_out <= sat(x_nx_s);
          y_out <= sat(y_nx_s);
          z_out <= z_nx_s;
        end else begin
          busy <= 1'b1;
        end
      end else begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter (DW=32, ITER=16): reset state, both modes,
// pre-rotation, handshake corner cases and output saturation.
module tb_cordic_iter;
  localparam int DW   = 32;
  localparam int ITER = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 mode;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_in;
  logic signed [31:0]   z_in;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] x_out;
  logic signed [DW-1:0] y_out;
  logic signed [31:0]   z_out;

  int checks   = 0;
  int failures = 0;
  int lat;
  int ndone;

  cordic_iter #(.DW(DW), .ITER(ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .busy  (busy),
    .done  (done),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    checks++;
    assert ((diff <= tol) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic drive(input logic m, input logic signed [DW-1:0] x,
                       input logic signed [DW-1:0] y, input logic signed [31:0] z);
    mode = m;
    x_in = x;
    y_in = y;
    z_in = z;
  endtask

  // Accept one operation, then wait (bounded) for done; l = cycles from acceptance
  task automatic wait_done(output int l);
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      tick;
      l++;
    end
  endtask

  task automatic run_op(input logic m, input logic signed [DW-1:0] x,
                        input logic signed [DW-1:0] y, input logic signed [31:0] z,
                        output int l);
    drive(m, x, y, z);
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(l);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    drive(1'b0, 32'sd0, 32'sd0, 32'sd0);
    repeat (3) tick;
    rst = 1'b0;
    repeat (5) tick;
    chk_eq("reset_busy", busy, 0);
    chk_eq("reset_done", done, 0);
    chk_eq("reset_x", x_out, 0);
    chk_eq("reset_y", y_out, 0);
    chk_eq("reset_z", z_out, 0);

    // Rotation by 30 degrees
    drive(1'b0, 32'sd65536, 32'sd0, 32'sd1966080);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk_eq("rot_busy_after_accept", busy, 1);
    wait_done(lat);
    chk_eq("rot_latency", lat, 16);
    chk_tol("rot_x", x_out, 93463, 16);
    chk_tol("rot_y", y_out, 53961, 16);
    chk_tol("rot_z", z_out, 0, 128);
    tick;
    chk_eq("done_one_cycle", done, 0);
    chk_eq("idle_after_done", busy, 0);

    // Vectoring of (1,1)
    run_op(1'b1, 32'sd65536, 32'sd65536, 32'sd0, lat);
    chk_eq("vec_latency", lat, 16);
    chk_tol("vec_x", x_out, 152624, 16);
    chk_tol("vec_y", y_out, 0, 16);
    chk_tol("vec_z", z_out, 2949120, 128);

    // Pre-rotation, rotation mode, 180 degrees
    run_op(1'b0, 32'sd65536, 32'sd0, 32'sd11796480, lat);
    chk_tol("prerot_rot_x", x_out, -107922, 16);
    chk_tol("prerot_rot_y", y_out, 0, 16);

    // Pre-rotation, vectoring mode, vector on negative x axis
    run_op(1'b1, -32'sd65536, 32'sd0, 32'sd0, lat);
    chk_tol("prerot_vec_x", x_out, 107922, 16);
    chk_tol("prerot_vec_z", z_out, 11796480, 128);

    // Start pulsed while busy is ignored; changed operands have no effect
    drive(1'b0, 32'sd65536, 32'sd0, 32'sd1966080);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    drive(1'b1, 32'sd65536, 32'sd65536, 32'sd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) ndone++;
      tick;
    end
    chk_eq("ignore_done_count", ndone, 1);
    chk_tol("ignore_x", x_out, 93463, 16);
    chk_tol("ignore_z", z_out, 0, 128);

    // Start held in the done cycle launches the next op back-to-back
    run_op(1'b0, 32'sd65536, 32'sd0, 32'sd1966080, lat);
    chk_eq("b2b_first_done", done, 1);
    drive(1'b0, 32'sd65536, 32'sd0, -32'sd1966080);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk_eq("b2b_busy", busy, 1);
    wait_done(lat);
    chk_eq("b2b_latency", lat, 16);
    chk_tol("b2b_x", x_out, 93463, 16);
    chk_tol("b2b_y", y_out, -53961, 16);

    // Reset mid-operation aborts with no done and clears outputs
    tick;
    drive(1'b0, 32'sd65536, 32'sd0, 32'sd1966080);
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (7) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_x", x_out, 0);
    chk_eq("abort_y", y_out, 0);
    chk_eq("abort_z", z_out, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) ndone++;
      tick;
    end
    chk_eq("abort_no_done", ndone, 0);
    run_op(1'b0, 32'sd65536, 32'sd0, 32'sd1966080, lat);
    chk_eq("after_abort_latency", lat, 16);
    chk_tol("after_abort_x", x_out, 93463, 16);
    chk_tol("after_abort_y", y_out, 53961, 16);

    // Saturation of the magnitude output
    tick;
    run_op(1'b1, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sd0, lat);
    chk_eq("sat_x", x_out, 64'sd2147483647);
    chk_tol("sat_z", z_out, 2949120, 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
